port_cam_only: RTL and testbench

//  Transport-port stage of the NMU ingress parser chain; sits directly after ip4_cam_only.

---
 rtl/nmu_parse_pkg.sv | 18 +
 rtl/port_cam_only_if.sv | 26 ++
 rtl/lane_extract.sv | 33 +++
 rtl/port_cam_only.sv | 115 +++++++++++
 tb/tb_port_cam_only.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/nmu_parse_pkg.sv
// Definitions shared by the NMU ingress parser stages: L4 header offsets and
// the per-stream parse state of the transport-port stage.
package nmu_parse_pkg;

  localparam int L4_DPORT_OFFSET        = 36;
  localparam int MAX_ADDED_OFFSET_CBITS = 7;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_DONE = 1'b1
  } port_state_t;

  // A zero-width tdest still needs one physical bit on the bus.
  function automatic int eff_width(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/port_cam_only_if.sv
// AXI-Stream bundle used on both sides of the port CAM stage.
interface port_cam_only_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
) ();

  logic [DATA_W-1:0]   tdata;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tid, tdest, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tid, tdest, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/lane_extract.sv
// Picks the 2-byte lane holding a header field at a given packet byte offset
// and flags whether that offset falls inside the current beat.
module lane_extract #(
  parameter int BUS_WIDTH = 64,
  parameter int POS_WIDTH = 11
) (
  input  logic [POS_WIDTH-1:0] offset,
  input  logic [POS_WIDTH-1:0] cur_pos,
  input  logic [BUS_WIDTH-1:0] tdata,
  output logic [15:0]          lane,
  output logic                 present
);

  localparam int LOG2B     = $clog2(BUS_WIDTH / 8);
  localparam int NUM_LANES = BUS_WIDTH / 16;

  logic [NUM_LANES-1:0][15:0] lanes;
  logic [LOG2B-2:0]           lane_idx;
  logic                       unused_bits;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lanes[gi] = tdata[gi*16 +: 16];
    end
  endgenerate

  // Offsets are even, so bit 0 never selects anything.
  assign lane_idx    = offset[LOG2B-1:1];
  assign lane        = lanes[lane_idx];
  assign present     = (offset[POS_WIDTH-1:LOG2B] == cur_pos[POS_WIDTH-1:LOG2B]);
  assign unused_bits = ^{offset[0], cur_pos[LOG2B-1:0]};

endmodule

// File: rtl/port_cam_only.sv
// Transport-port stage: pulls the L4 destination port off the passing stream,
// matches it against a per-ID port CAM and narrows the route mask accordingly.
module port_cam_only
  import nmu_parse_pkg::*;
#(
  parameter  int AXIS_BUS_WIDTH      = 64,
  parameter  int AXIS_ID_WIDTH       = 4,
  parameter  int AXIS_DEST_WIDTH     = 4,
  parameter  int MAX_PACKET_LENGTH   = 1522,
  parameter  int DROP_CNT_WIDTH      = 16,
  localparam int NUM_AXIS_ID         = 2 ** AXIS_ID_WIDTH,
  localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1)
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  port_cam_only_if.slave                        axis_in,
  port_cam_only_if.master                       axis_out,
  input  logic [NUM_AXIS_ID-1:0]                route_mask_in,
  input  logic                                  parsing_done_in,
  input  logic [PACKET_LENGTH_CBITS-1:0]        cur_pos_in,
  input  logic [MAX_ADDED_OFFSET_CBITS-1:0]     added_offset,
  input  logic                                  next_has_ports,
  output logic [NUM_AXIS_ID-1:0]                route_mask_out,
  output logic                                  parsing_done_out,
  output logic [PACKET_LENGTH_CBITS-1:0]        cur_pos_out,
  input  logic [NUM_AXIS_ID-1:0][15:0]          port_numbers,
  input  logic [NUM_AXIS_ID-1:0]                port_cam_must_match,
  output logic [DROP_CNT_WIDTH-1:0]             no_route_count
);

  logic                           valid_beat;
  logic                           last_beat;
  logic                           port_beat;
  logic                           dp_present;
  logic [15:0]                    dp_lane;
  logic [PACKET_LENGTH_CBITS-1:0] dp_off;

  port_state_t                    state_q, state_d;
  logic [NUM_AXIS_ID-1:0]         match_q, match_d;
  logic [NUM_AXIS_ID-1:0]         hit;
  logic [DROP_CNT_WIDTH-1:0]      count_q, count_d;

  assign axis_out.tdata  = axis_in.tdata;
  assign axis_out.tid    = axis_in.tid;
  assign axis_out.tdest  = axis_in.tdest;
  assign axis_out.tkeep  = axis_in.tkeep;
  assign axis_out.tlast  = axis_in.tlast;
  assign axis_out.tvalid = axis_in.tvalid;
  assign axis_in.tready  = axis_out.tready;
  assign cur_pos_out     = cur_pos_in;

  assign valid_beat = axis_in.tvalid & axis_out.tready;
  assign last_beat  = valid_beat & axis_in.tlast;
  assign dp_off     = PACKET_LENGTH_CBITS'(L4_DPORT_OFFSET) + PACKET_LENGTH_CBITS'(added_offset);

  lane_extract #(
    .BUS_WIDTH (AXIS_BUS_WIDTH),
    .POS_WIDTH (PACKET_LENGTH_CBITS)
  ) u_lane_extract (
    .offset  (dp_off),
    .cur_pos (cur_pos_in),
    .tdata   (axis_in.tdata),
    .lane    (dp_lane),
    .present (dp_present)
  );

  assign port_beat = dp_present & valid_beat & next_has_ports;

  always_comb begin
    state_d = state_q;
    if (last_beat) begin
      state_d = ST_WAIT;
    end else if (port_beat) begin
      state_d = ST_DONE;
    end
  end

  // A stored match only counts once the port has actually been seen, so a
  // runt packet that ends early drops every must-match entry.
  generate
    for (genvar gi = 0; gi < NUM_AXIS_ID; gi++) begin : g_cam
      assign match_d[gi] = last_beat ? 1'b1 :
                           (port_beat && (dp_lane != port_numbers[gi])) ? 1'b0 :
                           match_q[gi];
      assign hit[gi] = port_beat ? (dp_lane == port_numbers[gi]) :
                                   (match_q[gi] & (state_q == ST_DONE));
      assign route_mask_out[gi] = route_mask_in[gi] &
                                  (~port_cam_must_match[gi] | (next_has_ports & hit[gi]));
    end
  endgenerate

  assign parsing_done_out = next_has_ports ? (port_beat | (state_q == ST_DONE)) : parsing_done_in;

  always_comb begin
    count_d = count_q;
    if (last_beat && (route_mask_out == '0) && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_WAIT;
      match_q <= '1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign no_route_count = count_q;

endmodule

// File: tb/tb_port_cam_only.sv
// Directed bench for port_cam_only: packets are built as byte arrays and the
// expected route mask, done flag and drop count are derived from packet bytes.
module tb_port_cam_only;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  port_cam_only_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) in_if ();
  port_cam_only_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) out_if ();
  port_cam_only_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) in2_if ();
  port_cam_only_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) out2_if ();

  logic [3:0]       route_mask_in;
  logic             done_in;
  logic [10:0]      cur_pos;
  logic [6:0]       added_offset;
  logic             nhp;
  logic [3:0][15:0] port_numbers;
  logic [3:0]       must;
  logic [3:0]       mask_out, mask2;
  logic             done_out, done2;
  logic [10:0]      cpos_out, cpos2;
  logic [15:0]      cnt;
  logic [2:0]       cnt2;

  assign in2_if.tdata   = in_if.tdata;
  assign in2_if.tid     = in_if.tid;
  assign in2_if.tdest   = in_if.tdest;
  assign in2_if.tkeep   = in_if.tkeep;
  assign in2_if.tlast   = in_if.tlast;
  assign in2_if.tvalid  = in_if.tvalid;
  assign out2_if.tready = out_if.tready;

  port_cam_only #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(2), .AXIS_DEST_WIDTH(4),
                  .MAX_PACKET_LENGTH(1522), .DROP_CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .axis_in(in_if.slave), .axis_out(out_if.master),
    .route_mask_in(route_mask_in), .parsing_done_in(done_in), .cur_pos_in(cur_pos),
    .added_offset(added_offset), .next_has_ports(nhp), .route_mask_out(mask_out),
    .parsing_done_out(done_out), .cur_pos_out(cpos_out), .port_numbers(port_numbers),
    .port_cam_must_match(must), .no_route_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a few packets.
  port_cam_only #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(2), .AXIS_DEST_WIDTH(4),
                  .MAX_PACKET_LENGTH(1522), .DROP_CNT_WIDTH(3)) dut_sat (
    .aclk(aclk), .aresetn(aresetn), .axis_in(in2_if.slave), .axis_out(out2_if.master),
    .route_mask_in(route_mask_in), .parsing_done_in(done_in), .cur_pos_in(cur_pos),
    .added_offset(added_offset), .next_has_ports(nhp), .route_mask_out(mask2),
    .parsing_done_out(done2), .cur_pos_out(cpos2), .port_numbers(port_numbers),
    .port_cam_must_match(must), .no_route_count(cnt2)
  );

  logic [7:0] pkt [64];
  int nbeats = 0, b = 0, rst_beat = 0, dp = 36;
  int total = 0, bad = 0;
  int unsigned mcnt = 0, mcnt2 = 0;
  logic [3:0] last_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The destination port has been seen if its beat is accepted now, or was
  // accepted earlier in this packet after any mid-packet reset.
  function automatic logic port_seen();
    int  pb;
    logic acc;
    pb  = dp / 8;
    acc = in_if.tvalid && out_if.tready;
    return nhp && ((b == pb && acc) || (b > pb && pb >= rst_beat));
  endfunction

  function automatic logic [3:0] model_mask();
    logic [15:0] pv;
    logic [3:0]  m;
    pv = {pkt[dp+1], pkt[dp]};
    for (int k = 0; k < 4; k++)
      m[k] = route_mask_in[k] & (!must[k] || (port_seen() && pv == port_numbers[k]));
    return m;
  endfunction

  always @(negedge aclk) begin
    logic [3:0] em;
    if (!aresetn) begin
      mcnt  = 0;
      mcnt2 = 0;
    end
    em = model_mask();
    chk("route_mask", 64'(mask_out), 64'(em));
    chk("parsing_done", 64'(done_out), 64'(nhp ? port_seen() : done_in));
    chk("no_route_count", 64'(cnt), 64'(mcnt));
    chk("no_route_count_sat", 64'(cnt2), 64'(mcnt2));
    chk("tready", 64'(in_if.tready), 64'(out_if.tready));
    chk("tdata_pass", out_if.tdata, in_if.tdata);
    chk("cur_pos_pass", 64'(cpos_out), 64'(cur_pos));
    if (aresetn && in_if.tvalid && out_if.tready && in_if.tlast) begin
      last_mask = em;
      if (em == 4'h0) begin
        if (mcnt < 32'hFFFF) mcnt++;
        if (mcnt2 < 7) mcnt2++;
      end
    end
  end

  task automatic send_pkt(input string name, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic has_ports, input logic [3:0] mi,
                          input logic [6:0] added, input logic [31:0] rdy, input int rst_at);
    int  j;
    bit  did_rst;
    j = 0;
    did_rst = 0;
    for (int i = 0; i < 64; i++) pkt[i] = 8'(i * 7 + 3);
    dp = 36 + int'(added);
    pkt[dp] = b0;
    pkt[dp+1] = b1;
    nbeats = n; b = 0; rst_beat = 0;
    route_mask_in = mi; nhp = has_ports; added_offset = added;
    while (b < n) begin
      if (rst_at > 0 && b == rst_at && !did_rst) begin
        in_if.tvalid = 1'b0;
        aresetn = 1'b0;
        rst_beat = b;
        did_rst = 1;
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
      end
      for (int i = 0; i < 8; i++) in_if.tdata[i*8 +: 8] = pkt[b*8 + i];
      cur_pos = 11'(b * 8);
      in_if.tlast = (b == n - 1);
      in_if.tvalid = 1'b1;
      out_if.tready = rdy[j % 32];
      j++;
      @(posedge aclk); #1;
      if (out_if.tready) b++;
      if (j > 500) begin
        total++; bad++;
        $display("FAIL beat_budget: packet %s stuck at beat %0d", name, b);
        break;
      end
    end
    in_if.tvalid = 1'b0;
    in_if.tlast = 1'b0;
    b = 0;
    $display("pkt %-10s beats=%0d nhp=%0d mask_in=%h last_mask=%h count=%0d", name, n,
             has_ports, mi, last_mask, cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    in_if.tdata = '0; in_if.tid = 4'h1; in_if.tdest = 4'h2; in_if.tkeep = '1;
    in_if.tlast = 1'b0; in_if.tvalid = 1'b0; out_if.tready = 1'b1;
    route_mask_in = 4'h0; done_in = 1'b0; cur_pos = '0; added_offset = '0; nhp = 1'b0;
    port_numbers[0] = 16'h5000; port_numbers[1] = 16'h3412;
    port_numbers[2] = 16'hBEEF; port_numbers[3] = 16'h0000;
    must = 4'b0111;
    for (int i = 0; i < 64; i++) pkt[i] = '0;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("reset_count", 64'(cnt), 64'd0);
    chk("reset_count_sat", 64'(cnt2), 64'd0);

    send_pkt("udp", 8, 8'h12, 8'h34, 1'b1, 4'hF, 7'd0, 32'hFFFF_FFFF, 0);
    chk("udp_mask", 64'(last_mask), 64'b1010);
    send_pkt("tcp_tag", 8, 8'h00, 8'h50, 1'b1, 4'hF, 7'd8, 32'hFFFF_FFFF, 0);
    chk("tcp_mask", 64'(last_mask), 64'b1001);
    done_in = 1'b1;
    send_pkt("icmp", 6, 8'h12, 8'h34, 1'b0, 4'hF, 7'd0, 32'hFFFF_FFFF, 0);
    chk("icmp_mask", 64'(last_mask), 64'b1000);
    done_in = 1'b0;
    send_pkt("nomatch", 8, 8'hAA, 8'hBB, 1'b1, 4'h7, 7'd0, 32'hFFFF_FFFF, 0);
    chk("nomatch_mask", 64'(last_mask), 64'b0000);
    chk("nomatch_count", 64'(cnt), 64'd1);
    for (int r = 0; r < 9; r++)
      send_pkt("runt_empty", 1, 8'h12, 8'h34, 1'b1, 4'h7, 7'd0, 32'hFFFF_FFFF, 0);
    chk("sat_count", 64'(cnt2), 64'd7);
    chk("wide_count", 64'(cnt), 64'd10);
    send_pkt("runt_f", 2, 8'h12, 8'h34, 1'b1, 4'hF, 7'd0, 32'h5555_5555, 0);
    chk("runt_mask", 64'(last_mask), 64'b1000);
    send_pkt("port_last", 5, 8'h12, 8'h34, 1'b1, 4'hF, 7'd0, 32'hAAAA_AAAA, 0);
    chk("port_last_mask", 64'(last_mask), 64'b1010);
    send_pkt("after_last", 8, 8'hEF, 8'hBE, 1'b1, 4'hF, 7'd0, 32'h6DB6_DB6D, 0);
    chk("after_last_mask", 64'(last_mask), 64'b1100);
    send_pkt("mid_reset", 8, 8'h12, 8'h34, 1'b1, 4'hF, 7'd0, 32'hFFFF_FFFF, 3);
    chk("mid_reset_mask", 64'(last_mask), 64'b1010);
    chk("mid_reset_count", 64'(cnt), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
